// File: rtl/flood_cfg_pkg.sv
// Shared types, field widths, reset defaults and the tries-budget helper for
// the Flood-It game controller.
package flood_cfg_pkg;

  localparam int SIZE_W      = 5;
  localparam int COLOR_W     = 4;
  localparam int BUDGET_W    = 13;
  localparam int SIZE_DEF_P  = 14;
  localparam int COLOR_DEF_P = 6;

  typedef enum logic [2:0] {
    S_CONFIG,
    S_INIT,
    S_START,
    S_PLAY,
    S_OVER
  } state_t;

  typedef enum logic {
    F_COLOR = 1'b0,
    F_SIZE  = 1'b1
  } field_t;

  // Move budget: max(1, (size * (colors-1) * try_num) >> try_shift) on a 13-bit product.
  function automatic logic [BUDGET_W-1:0] tries_budget(
    input logic [SIZE_W-1:0]  size,
    input logic [COLOR_W-1:0] colors,
    input int                 try_num,
    input int                 try_shift
  );
    logic [BUDGET_W-1:0] prod;
    prod = BUDGET_W'(size) * BUDGET_W'(colors - 1'b1) * BUDGET_W'(try_num);
    prod = prod >> try_shift;
    return (prod == '0) ? BUDGET_W'(1) : prod;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-time filter; emits a one-cycle pulse on an
// accepted press, so a held button yields exactly one pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt_done) begin
        stable <= sync[1];
        cnt    <= '0;
        rise   <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flood_game_controller.sv
// Flood-It menu/select controller: debounced buttons, config editing, board
// init/start sequencing and play-time colour requests. Optional: TRIES_LIMIT_EN.
module flood_game_controller
  import flood_cfg_pkg::*;
#(
  parameter int SW_W            = 8,
  parameter int COLOR_MIN       = 3,
  parameter int SIZE_MIN        = 2,
  parameter int SIZE_STEP       = 4,
  parameter int SIZE_STEPS      = 7,
  parameter int SIZE_DEF        = SIZE_DEF_P,
  parameter int COLOR_DEF       = COLOR_DEF_P,
  parameter int TRIES_W         = 8,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TRY_NUM         = 23,
  parameter int TRY_SHIFT       = 6
) (
  input  logic                    MASTER_CLOCK,
  input  logic                    RESET_N,
  input  logic                    UP,
  input  logic                    DOWN,
  input  logic                    LEFT,
  input  logic                    RIGHT,
  input  logic                    CENTER,
  input  logic [SW_W-1:0]         sw,
  input  logic                    BOARD_READY,
  input  logic                    ACK_BEGIN_GAME,
  input  logic                    GAME_WON,
  input  logic                    COLOR_SEL_READY,
  output logic                    INIT_BOARD,
  output logic                    BEGIN_GAME,
  output logic                    MODE,
  output logic                    FIELD_SEL,
  output logic [4:0]              SIZE,
  output logic [3:0]              COLOR_NUM,
  output logic [4:0]              final_SIZE,
  output logic [3:0]              final_COLOR_NUM,
  output logic [TRIES_W-1:0]      TRIES,
  output logic [TRIES_W-1:0]      TRIES_LEFT,
  output logic                    GAME_OVER,
  output logic                    COLOR_SEL_VALID,
  output logic [$clog2(SW_W)-1:0] COLOR_SELECTED
);

  localparam int SEL_W    = $clog2(SW_W);
  localparam int SIZE_MAX = SIZE_MIN + (SIZE_STEPS - 1) * SIZE_STEP;

  state_t            state;
  field_t            field_sel;
  logic              game_valid;
  logic [SW_W-1:0]   sw_q;
  logic              up_p, down_p, left_p, right_p, center_p;
  logic              sel_hit;
  logic [SEL_W-1:0]  sel_idx;
  logic              accept;
  logic [TRIES_W-1:0] tries_inc;
  logic              budget_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up     (.clk(MASTER_CLOCK), .rst_n(RESET_N), .btn(UP),     .rise(up_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down   (.clk(MASTER_CLOCK), .rst_n(RESET_N), .btn(DOWN),   .rise(down_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left   (.clk(MASTER_CLOCK), .rst_n(RESET_N), .btn(LEFT),   .rise(left_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right  (.clk(MASTER_CLOCK), .rst_n(RESET_N), .btn(RIGHT),  .rise(right_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_center (.clk(MASTER_CLOCK), .rst_n(RESET_N), .btn(CENTER), .rise(center_p));

  function automatic logic [SIZE_W-1:0] size_step(input logic [SIZE_W-1:0] s, input logic up);
    if (up) return (s >= SIZE_W'(SIZE_MAX)) ? SIZE_W'(SIZE_MIN) : s + SIZE_W'(SIZE_STEP);
    else    return (s <= SIZE_W'(SIZE_MIN)) ? SIZE_W'(SIZE_MAX) : s - SIZE_W'(SIZE_STEP);
  endfunction

  function automatic logic [COLOR_W-1:0] color_step(input logic [COLOR_W-1:0] c, input logic up);
    if (up) return (c >= COLOR_W'(SW_W))      ? COLOR_W'(COLOR_MIN) : c + 1'b1;
    else    return (c <= COLOR_W'(COLOR_MIN)) ? COLOR_W'(SW_W)      : c - 1'b1;
  endfunction

  // Lowest toggled switch that maps to a colour in play wins.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = SW_W - 1; i >= 0; i--) begin
      if ((sw[i] != sw_q[i]) && (i < int'(final_COLOR_NUM))) begin
        sel_hit = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

  assign accept    = COLOR_SEL_VALID & COLOR_SEL_READY;
  assign tries_inc = (TRIES == '1) ? TRIES : TRIES + 1'b1;
  assign FIELD_SEL = field_sel;

`ifdef TRIES_LIMIT_EN
  logic [TRIES_W-1:0] budget;

  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      budget <= '0;
    end else if (state == S_CONFIG && center_p) begin
      budget <= TRIES_W'(tries_budget(SIZE, COLOR_NUM, TRY_NUM, TRY_SHIFT));
    end
  end

  assign budget_hit = accept && (tries_inc == budget);
  assign TRIES_LEFT = budget - TRIES;
`else
  assign budget_hit = 1'b0;
  assign TRIES_LEFT = '0;
`endif

  always_ff @(posedge MASTER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state           <= S_CONFIG;
      field_sel       <= F_COLOR;
      game_valid      <= 1'b0;
      sw_q            <= '0;
      INIT_BOARD      <= 1'b0;
      BEGIN_GAME      <= 1'b0;
      MODE            <= 1'b0;
      SIZE            <= SIZE_W'(SIZE_DEF);
      COLOR_NUM       <= COLOR_W'(COLOR_DEF);
      final_SIZE      <= SIZE_W'(SIZE_DEF);
      final_COLOR_NUM <= COLOR_W'(COLOR_DEF);
      TRIES           <= '0;
      GAME_OVER       <= 1'b0;
      COLOR_SEL_VALID <= 1'b0;
      COLOR_SELECTED  <= '0;
    end else begin
      sw_q <= sw;
      // A pending request completes in any state, so pausing never strands it.
      if (accept) begin
        COLOR_SEL_VALID <= 1'b0;
        TRIES           <= tries_inc;
      end

      case (state)
        S_CONFIG: begin
          if (left_p) field_sel <= (field_sel == F_SIZE) ? F_COLOR : F_SIZE;
          if (up_p ^ down_p) begin
            if (field_sel == F_SIZE) SIZE      <= size_step(SIZE, up_p);
            else                     COLOR_NUM <= color_step(COLOR_NUM, up_p);
          end
          if (center_p) begin
            final_SIZE      <= SIZE;
            final_COLOR_NUM <= COLOR_NUM;
            TRIES           <= '0;
            game_valid      <= 1'b0;
            INIT_BOARD      <= 1'b1;
            state           <= S_INIT;
          end else if (right_p && game_valid) begin
            MODE  <= 1'b1;
            state <= S_PLAY;
          end
        end

        S_INIT: begin
          if (BOARD_READY) begin
            INIT_BOARD <= 1'b0;
            BEGIN_GAME <= 1'b1;
            state      <= S_START;
          end
        end

        S_START: begin
          if (ACK_BEGIN_GAME) begin
            BEGIN_GAME <= 1'b0;
            game_valid <= 1'b1;
            MODE       <= 1'b1;
            state      <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (sel_hit && !COLOR_SEL_VALID) begin
            COLOR_SEL_VALID <= 1'b1;
            COLOR_SELECTED  <= sel_idx;
          end
          if (GAME_WON || budget_hit) begin
            GAME_OVER <= 1'b1;
            state     <= S_OVER;
          end else if (right_p) begin
            MODE  <= 1'b0;
            state <= S_CONFIG;
          end
        end

        S_OVER: begin
          if (center_p || right_p) begin
            GAME_OVER  <= 1'b0;
            game_valid <= 1'b0;
            MODE       <= 1'b0;
            state      <= S_CONFIG;
          end
        end

        default: state <= S_CONFIG;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_game_controller.sv
// Directed bench for flood_game_controller with a short debounce window;
// expectations follow TRIES_LIMIT_EN when it is defined.
module tb_flood_game_controller;

  logic       MASTER_CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       UP = 1'b0, DOWN = 1'b0, LEFT = 1'b0, RIGHT = 1'b0, CENTER = 1'b0;
  logic [7:0] sw = '0;
  logic       BOARD_READY = 1'b0, ACK_BEGIN_GAME = 1'b0, GAME_WON = 1'b0, COLOR_SEL_READY = 1'b0;
  logic       INIT_BOARD, BEGIN_GAME, MODE, FIELD_SEL, GAME_OVER, COLOR_SEL_VALID;
  logic [4:0] SIZE, final_SIZE;
  logic [3:0] COLOR_NUM, final_COLOR_NUM;
  logic [7:0] TRIES, TRIES_LEFT;
  logic [2:0] COLOR_SELECTED;

  int checks = 0;
  int errors = 0;

  flood_game_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .MASTER_CLOCK(MASTER_CLOCK), .RESET_N(RESET_N),
    .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT), .CENTER(CENTER),
    .sw(sw), .BOARD_READY(BOARD_READY), .ACK_BEGIN_GAME(ACK_BEGIN_GAME),
    .GAME_WON(GAME_WON), .COLOR_SEL_READY(COLOR_SEL_READY),
    .INIT_BOARD(INIT_BOARD), .BEGIN_GAME(BEGIN_GAME), .MODE(MODE), .FIELD_SEL(FIELD_SEL),
    .SIZE(SIZE), .COLOR_NUM(COLOR_NUM), .final_SIZE(final_SIZE), .final_COLOR_NUM(final_COLOR_NUM),
    .TRIES(TRIES), .TRIES_LEFT(TRIES_LEFT), .GAME_OVER(GAME_OVER),
    .COLOR_SEL_VALID(COLOR_SEL_VALID), .COLOR_SELECTED(COLOR_SELECTED)
  );

  always #5 MASTER_CLOCK = ~MASTER_CLOCK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge MASTER_CLOCK);
      #1;
    end
  endtask

  // mask = {UP, DOWN, LEFT, RIGHT, CENTER}
  task automatic press(input logic [4:0] mask, input int hold = 12);
    {UP, DOWN, LEFT, RIGHT, CENTER} = mask;
    tick(hold);
    {UP, DOWN, LEFT, RIGHT, CENTER} = '0;
    tick(12);
  endtask

  task automatic start_game(input string tag, input logic [4:0] exp_size, input logic [3:0] exp_colors);
    press(5'b00001);
    checks++; if (INIT_BOARD !== 1'b1) begin errors++; $display("FAIL %s_init_req: got %b expected 1", tag, INIT_BOARD); end
    checks++; if (final_SIZE !== exp_size) begin errors++; $display("FAIL %s_final_size: got %0d expected %0d", tag, final_SIZE, exp_size); end
    checks++; if (final_COLOR_NUM !== exp_colors) begin errors++; $display("FAIL %s_final_colors: got %0d expected %0d", tag, final_COLOR_NUM, exp_colors); end
    tick(5);
    checks++; if (INIT_BOARD !== 1'b1 || BEGIN_GAME !== 1'b0) begin errors++; $display("FAIL %s_init_hold: got init=%b begin=%b expected 1/0", tag, INIT_BOARD, BEGIN_GAME); end
    BOARD_READY = 1'b1; tick(); BOARD_READY = 1'b0;
    checks++; if (INIT_BOARD !== 1'b0 || BEGIN_GAME !== 1'b1) begin errors++; $display("FAIL %s_begin_req: got init=%b begin=%b expected 0/1", tag, INIT_BOARD, BEGIN_GAME); end
    tick(4);
    checks++; if (BEGIN_GAME !== 1'b1 || MODE !== 1'b0) begin errors++; $display("FAIL %s_begin_hold: got begin=%b mode=%b expected 1/0", tag, BEGIN_GAME, MODE); end
    ACK_BEGIN_GAME = 1'b1; tick(); ACK_BEGIN_GAME = 1'b0;
    checks++; if (BEGIN_GAME !== 1'b0 || MODE !== 1'b1) begin errors++; $display("FAIL %s_play: got begin=%b mode=%b expected 0/1", tag, BEGIN_GAME, MODE); end
    checks++; if (TRIES !== 8'd0) begin errors++; $display("FAIL %s_tries0: got %0d expected 0", tag, TRIES); end
  endtask

  task automatic test_reset();
    checks++; if (SIZE !== 5'd14 || final_SIZE !== 5'd14) begin errors++; $display("FAIL reset_size: got %0d/%0d expected 14/14", SIZE, final_SIZE); end
    checks++; if (COLOR_NUM !== 4'd6 || final_COLOR_NUM !== 4'd6) begin errors++; $display("FAIL reset_colors: got %0d/%0d expected 6/6", COLOR_NUM, final_COLOR_NUM); end
    checks++; if ({MODE, INIT_BOARD, BEGIN_GAME, COLOR_SEL_VALID, GAME_OVER, FIELD_SEL} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000", {MODE, INIT_BOARD, BEGIN_GAME, COLOR_SEL_VALID, GAME_OVER, FIELD_SEL}); end
    checks++; if (TRIES !== 8'd0 || TRIES_LEFT !== 8'd0) begin errors++; $display("FAIL reset_tries: got %0d/%0d expected 0/0", TRIES, TRIES_LEFT); end
  endtask

  task automatic test_size_wrap();
    press(5'b00100);
    checks++; if (FIELD_SEL !== 1'b1) begin errors++; $display("FAIL field_toggle: got %b expected 1", FIELD_SEL); end
    for (int i = 0; i < 3; i++) press(5'b10000);
    checks++; if (SIZE !== 5'd26) begin errors++; $display("FAIL size_max: got %0d expected 26", SIZE); end
    press(5'b10000);
    checks++; if (SIZE !== 5'd2) begin errors++; $display("FAIL size_wrap_up: got %0d expected 2", SIZE); end
    checks++; if (COLOR_NUM !== 4'd6) begin errors++; $display("FAIL size_edit_color_kept: got %0d expected 6", COLOR_NUM); end
  endtask

  task automatic test_color_wrap();
    press(5'b00100);
    for (int i = 0; i < 3; i++) press(5'b01000);
    checks++; if (COLOR_NUM !== 4'd3) begin errors++; $display("FAIL color_min: got %0d expected 3", COLOR_NUM); end
    press(5'b01000);
    checks++; if (COLOR_NUM !== 4'd8) begin errors++; $display("FAIL color_wrap_down: got %0d expected 8", COLOR_NUM); end
    press(5'b11000);
    checks++; if (COLOR_NUM !== 4'd8 || SIZE !== 5'd2) begin errors++; $display("FAIL up_down_same: got %0d/%0d expected 8/2", COLOR_NUM, SIZE); end
  endtask

  task automatic test_debounce();
    press(5'b10000, 2);
    checks++; if (COLOR_NUM !== 4'd8) begin errors++; $display("FAIL glitch_rejected: got %0d expected 8", COLOR_NUM); end
    press(5'b10000, 40);
    checks++; if (COLOR_NUM !== 4'd3) begin errors++; $display("FAIL held_one_pulse: got %0d expected 3", COLOR_NUM); end
    for (int i = 0; i < 3; i++) press(5'b10000);
    press(5'b00100);
    for (int i = 0; i < 3; i++) press(5'b10000);
    checks++; if (COLOR_NUM !== 4'd6 || SIZE !== 5'd14) begin errors++; $display("FAIL restore_menu: got %0d/%0d expected 6/14", COLOR_NUM, SIZE); end
  endtask

  task automatic test_select();
    start_game("game1", 5'd14, 4'd6);
`ifdef TRIES_LIMIT_EN
    checks++; if (TRIES_LEFT !== 8'd25) begin errors++; $display("FAIL budget_14_6: got %0d expected 25", TRIES_LEFT); end
`else
    checks++; if (TRIES_LEFT !== 8'd0) begin errors++; $display("FAIL tries_left_off: got %0d expected 0", TRIES_LEFT); end
`endif
    sw[2] = ~sw[2]; tick();
    checks++; if (COLOR_SEL_VALID !== 1'b1 || COLOR_SELECTED !== 3'd2) begin
      errors++; $display("FAIL sel_req: got valid=%b sel=%0d expected 1/2", COLOR_SEL_VALID, COLOR_SELECTED); end
    tick(5);
    checks++; if (COLOR_SEL_VALID !== 1'b1 || COLOR_SELECTED !== 3'd2 || TRIES !== 8'd0) begin
      errors++; $display("FAIL sel_hold: got valid=%b sel=%0d tries=%0d expected 1/2/0", COLOR_SEL_VALID, COLOR_SELECTED, TRIES); end
    COLOR_SEL_READY = 1'b1; tick(); COLOR_SEL_READY = 1'b0;
    checks++; if (COLOR_SEL_VALID !== 1'b0 || TRIES !== 8'd1) begin
      errors++; $display("FAIL sel_accept: got valid=%b tries=%0d expected 0/1", COLOR_SEL_VALID, TRIES); end
`ifdef TRIES_LIMIT_EN
    checks++; if (TRIES_LEFT !== 8'd24) begin errors++; $display("FAIL tries_left_dec: got %0d expected 24", TRIES_LEFT); end
`endif
    sw[7] = ~sw[7]; tick(3);
    checks++; if (COLOR_SEL_VALID !== 1'b0 || TRIES !== 8'd1) begin
      errors++; $display("FAIL out_of_range_ignored: got valid=%b tries=%0d expected 0/1", COLOR_SEL_VALID, TRIES); end
  endtask

  task automatic test_back_to_back();
    sw[0] = ~sw[0]; tick();
    checks++; if (COLOR_SEL_VALID !== 1'b1 || COLOR_SELECTED !== 3'd0) begin
      errors++; $display("FAIL b2b_first: got valid=%b sel=%0d expected 1/0", COLOR_SEL_VALID, COLOR_SELECTED); end
    sw[1] = ~sw[1]; tick(2);
    checks++; if (COLOR_SELECTED !== 3'd0) begin errors++; $display("FAIL b2b_no_overwrite: got %0d expected 0", COLOR_SELECTED); end
    COLOR_SEL_READY = 1'b1; tick(); COLOR_SEL_READY = 1'b0;
    tick(2);
    checks++; if (COLOR_SEL_VALID !== 1'b0 || TRIES !== 8'd2) begin
      errors++; $display("FAIL b2b_dropped: got valid=%b tries=%0d expected 0/2", COLOR_SEL_VALID, TRIES); end
  endtask

  task automatic test_pause_resume();
    press(5'b00010);
    checks++; if (MODE !== 1'b0) begin errors++; $display("FAIL pause: got mode=%b expected 0", MODE); end
    press(5'b00010);
    checks++; if (MODE !== 1'b1 || TRIES !== 8'd2) begin errors++; $display("FAIL resume: got mode=%b tries=%0d expected 1/2", MODE, TRIES); end
  endtask

  task automatic test_game_won();
    GAME_WON = 1'b1; tick(); GAME_WON = 1'b0;
    checks++; if (GAME_OVER !== 1'b1 || MODE !== 1'b1) begin errors++; $display("FAIL won_over: got over=%b mode=%b expected 1/1", GAME_OVER, MODE); end
    sw[3] = ~sw[3]; tick(2);
    checks++; if (COLOR_SEL_VALID !== 1'b0) begin errors++; $display("FAIL over_no_select: got %b expected 0", COLOR_SEL_VALID); end
    press(5'b00001);
    checks++; if (GAME_OVER !== 1'b0 || MODE !== 1'b0 || INIT_BOARD !== 1'b0) begin
      errors++; $display("FAIL over_exit: got over=%b mode=%b init=%b expected 0/0/0", GAME_OVER, MODE, INIT_BOARD); end
    press(5'b00010);
    checks++; if (MODE !== 1'b0) begin errors++; $display("FAIL no_resume_after_over: got mode=%b expected 0", MODE); end
  endtask

  task automatic test_budget();
    for (int i = 0; i < 3; i++) press(5'b01000);
    press(5'b00100);
    for (int i = 0; i < 3; i++) press(5'b01000);
    checks++; if (SIZE !== 5'd2 || COLOR_NUM !== 4'd3) begin errors++; $display("FAIL menu_2_3: got %0d/%0d expected 2/3", SIZE, COLOR_NUM); end
    start_game("game2", 5'd2, 4'd3);
`ifdef TRIES_LIMIT_EN
    checks++; if (TRIES_LEFT !== 8'd1) begin errors++; $display("FAIL budget_2_3: got %0d expected 1", TRIES_LEFT); end
`endif
    sw[0] = ~sw[0]; tick();
    COLOR_SEL_READY = 1'b1; tick(); COLOR_SEL_READY = 1'b0;
    checks++; if (TRIES !== 8'd1) begin errors++; $display("FAIL budget_tries: got %0d expected 1", TRIES); end
`ifdef TRIES_LIMIT_EN
    checks++; if (GAME_OVER !== 1'b1 || TRIES_LEFT !== 8'd0) begin
      errors++; $display("FAIL budget_over: got over=%b left=%0d expected 1/0", GAME_OVER, TRIES_LEFT); end
`else
    tick(3);
    checks++; if (GAME_OVER !== 1'b0) begin errors++; $display("FAIL no_budget_over: got %b expected 0", GAME_OVER); end
    GAME_WON = 1'b1; tick(); GAME_WON = 1'b0;
    checks++; if (GAME_OVER !== 1'b1) begin errors++; $display("FAIL won_over2: got %b expected 1", GAME_OVER); end
`endif
    press(5'b00001);
    checks++; if (GAME_OVER !== 1'b0 || MODE !== 1'b0) begin errors++; $display("FAIL budget_exit: got over=%b mode=%b expected 0/0", GAME_OVER, MODE); end
  endtask

  task automatic test_reset_mid_init();
    press(5'b00001);
    checks++; if (INIT_BOARD !== 1'b1 || final_SIZE !== 5'd2) begin
      errors++; $display("FAIL mid_init_setup: got init=%b fsize=%0d expected 1/2", INIT_BOARD, final_SIZE); end
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (INIT_BOARD !== 1'b0 || final_SIZE !== 5'd14 || SIZE !== 5'd14 || MODE !== 1'b0) begin
      errors++; $display("FAIL async_reset: got init=%b fsize=%0d size=%0d mode=%b expected 0/14/14/0", INIT_BOARD, final_SIZE, SIZE, MODE); end
    tick(2);
    RESET_N = 1'b1;
    tick(2);
    press(5'b00010);
    checks++; if (MODE !== 1'b0 || INIT_BOARD !== 1'b0 || BEGIN_GAME !== 1'b0) begin
      errors++; $display("FAIL reset_no_resume: got mode=%b init=%b begin=%b expected 0/0/0", MODE, INIT_BOARD, BEGIN_GAME); end
  endtask

  initial begin
    tick(3);
    RESET_N = 1'b1;
    tick();
    test_reset();
    test_size_wrap();
    test_color_wrap();
    test_debounce();
    test_select();
    test_back_to_back();
    test_pause_resume();
    test_game_won();
    test_budget();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
